// File: rtl/lenet_pkg.sv
// Shared constants and types for the LeNet pooled-map reader.
package lenet_pkg;

    localparam int DATA_WIDTH = 12;
    localparam int MAP_DIM    = 5;
    localparam int MAP_SIZE   = MAP_DIM * MAP_DIM;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

    // Linear element offset of (row, col); row runs fastest, so this walks 0,1,2,...
    function automatic logic [4:0] elem_offset(input logic [2:0] row, input logic [2:0] col, input int dim);
        return {2'b00, row} + 5'({2'b00, col} * 5'(dim));
    endfunction

endpackage

// File: rtl/pool_buffer_reader_if.sv
// Control, buffer-read and FC-stream signals of the pooled-map reader.
interface pool_buffer_reader_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_position;
    logic [ADDR_WIDTH-1:0] L4_output_read_addr;
    logic                  L4_output_rd_en;
    logic [DATA_WIDTH-1:0] L4_output_dout;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [4:0]            m_index;
    logic                  m_last;
    logic                  busy;
    logic                  read_done;

    // Reader side
    modport slave (
        input  start, base_position, L4_output_dout, m_ready,
        output L4_output_read_addr, L4_output_rd_en, m_valid, m_data, m_index, m_last, busy, read_done
    );

    // Controller / buffer / consumer side
    modport master (
        output start, base_position, L4_output_dout, m_ready,
        input  L4_output_read_addr, L4_output_rd_en, m_valid, m_data, m_index, m_last, busy, read_done
    );
endinterface

// File: rtl/pool_rd_fifo.sv
// Two-entry FIFO holding returned buffer words until the FC stream takes them.
module pool_rd_fifo #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count,
    output logic             o_full,
    output logic             o_empty
);
    logic [WIDTH-1:0] r_mem [0:1];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Qualify push/pop; a push into a full FIFO is only taken alongside a pop
    always_comb begin
        w_do_pop  = i_pop && (r_count != 2'd0);
        w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head word reads as zero while empty so the stream outputs idle at zero
    always_comb begin
        if (r_count == 2'd0) begin
            o_data = {WIDTH{1'b0}};
        end else begin
            o_data = r_mem[r_rd_ptr];
        end
    end

    assign o_count = r_count;
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/pool_buffer_reader.sv
// Streams one MAP_DIM x MAP_DIM pooled map from the L4 output buffer to the FC layer.
// Reads are throttled so that FIFO contents plus the read returning on dout never
// exceed two words, which lets a one-cycle-latency buffer sustain one beat per cycle.
module pool_buffer_reader #(
    parameter int DATA_WIDTH = lenet_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = 8,
    parameter int MAP_DIM    = lenet_pkg::MAP_DIM
) (
    input  logic                 clk,
    input  logic                 rst,
    pool_buffer_reader_if.slave  bus
);
    import lenet_pkg::*;

    localparam int MAP_SZ = MAP_DIM * MAP_DIM;
    localparam int FW     = DATA_WIDTH + 6;   // {last, index[4:0], data}

    rd_state_t             r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [2:0]            r_row;
    logic [2:0]            r_col;
    logic [4:0]            r_ret_idx;
    logic                  r_armed;
    logic                  r_rd_dly;
    logic                  r_busy;
    logic                  r_read_done;

    logic [FW-1:0]         w_push_data;
    logic [FW-1:0]         w_head;
    logic [1:0]            w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_last_issue;
    logic [2:0]            w_occ;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    // Read issue: occupancy after this cycle's pop plus the word on dout must stay below two
    always_comb begin
        w_pop        = !w_empty && bus.m_ready;
        w_occ        = {1'b0, w_count} + {2'b00, r_rd_dly} - {2'b00, w_pop};
        w_last_issue = (r_row == 3'(MAP_DIM - 1)) && (r_col == 3'(MAP_DIM - 1));
        if (!rst && (r_state == READ) && r_armed && (w_occ < 3'd2) && !(w_full && !w_pop)) begin
            w_issue = 1'b1;
        end else begin
            w_issue = 1'b0;
        end
        if (w_issue) begin
            w_rd_addr = r_base + ADDR_WIDTH'(elem_offset(r_row, r_col, MAP_DIM));
        end else begin
            w_rd_addr = {ADDR_WIDTH{1'b0}};
        end
    end

    assign w_push_data = {(r_ret_idx == 5'(MAP_SZ - 1)), r_ret_idx, bus.L4_output_dout};

    pool_rd_fifo #(.WIDTH(FW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_rd_dly),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Sequencer: start latch, read walk, drain of the final beat and completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_base      <= {ADDR_WIDTH{1'b0}};
            r_row       <= 3'd0;
            r_col       <= 3'd0;
            r_ret_idx   <= 5'd0;
            r_armed     <= 1'b0;
            r_rd_dly    <= 1'b0;
            r_busy      <= 1'b0;
            r_read_done <= 1'b0;
        end else begin
            r_rd_dly    <= w_issue;
            r_read_done <= 1'b0;
            if (r_rd_dly) begin
                r_ret_idx <= r_ret_idx + 5'd1;
            end
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_base    <= bus.base_position;
                        r_row     <= 3'd0;
                        r_col     <= 3'd0;
                        r_ret_idx <= 5'd0;
                        r_armed   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= READ;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                READ: begin
                    // One settling cycle after start before the first read goes out
                    r_armed <= 1'b1;
                    if (w_issue) begin
                        if (r_row == 3'(MAP_DIM - 1)) begin
                            r_row <= 3'd0;
                            r_col <= r_col + 3'd1;
                        end else begin
                            r_row <= r_row + 3'd1;
                        end
                        if (w_last_issue) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop && w_head[FW-1]) begin
                        r_busy      <= 1'b0;
                        r_read_done <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.L4_output_rd_en     = w_issue;
    assign bus.L4_output_read_addr = w_rd_addr;
    assign bus.m_valid             = !w_empty;
    assign bus.m_data              = w_head[DATA_WIDTH-1:0];
    assign bus.m_index             = w_head[DATA_WIDTH+4:DATA_WIDTH];
    assign bus.m_last              = w_head[FW-1];
    assign bus.busy                = r_busy;
    assign bus.read_done           = r_read_done;

endmodule

// File: tb/tb_pool_buffer_reader.sv
// Scoreboard bench for pool_buffer_reader with a one-cycle-latency buffer model mem[a]=a*3.
module tb_pool_buffer_reader;

    typedef struct packed {
        logic [11:0] data;
        logic [4:0]  idx;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pool_buffer_reader_if #(.DATA_WIDTH(12), .ADDR_WIDTH(8)) bus ();

    pool_buffer_reader #(.DATA_WIDTH(12), .ADDR_WIDTH(8), .MAP_DIM(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    beat_t       exp_q[$];
    logic [7:0]  addr_q[$];
    logic [11:0] mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int issued   = 0;
    int accepted = 0;
    int max_out  = 0;
    int done_cnt = 0;
    int beats_run = 0;
    int first_cyc = 0;
    int last_cyc  = 0;
    int stall_left = 0;
    int ready_mode = 0;
    logic        prev_stall = 1'b0;
    logic        last_prev  = 1'b0;
    logic [11:0] held_data;
    logic [4:0]  held_idx;
    logic        held_last;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Buffer model: data appears on dout one cycle after the read strobe
    always @(posedge clk) begin
        if (bus.L4_output_rd_en) bus.L4_output_dout <= mem[bus.L4_output_read_addr];
    end

    // Consumer ready pattern
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.m_ready = 1'b1;
                1: bus.m_ready = ~bus.m_ready;
                2: begin
                    if (bus.m_valid && bus.m_index == 5'd7 && stall_left > 0) begin
                        bus.m_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus.m_ready = 1'b1;
                    end
                end
                default: bus.m_ready = 1'b1;
            endcase
        end
    end

    // Monitor: read addresses, beats, stability under stall, completion pulse
    always @(negedge clk) begin
        beat_t b;
        logic  xfer;
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
            last_prev  = 1'b0;
            issued     = 0;
            accepted   = 0;
        end else begin
            if (bus.L4_output_rd_en) begin
                issued++;
                if (addr_q.size() == 0) check_eq("unexpected_read", 32'(bus.L4_output_read_addr), 32'hFFFF_FFFF);
                else check_eq("read_addr", 32'(bus.L4_output_read_addr), 32'(addr_q.pop_front()));
            end
            if (prev_stall) begin
                check_eq("hold_valid", 32'(bus.m_valid), 32'd1);
                check_eq("hold_data", 32'(bus.m_data), 32'(held_data));
                check_eq("hold_index", 32'(bus.m_index), 32'(held_idx));
                check_eq("hold_last", 32'(bus.m_last), 32'(held_last));
            end
            if (bus.read_done) begin
                done_cnt++;
                check_eq("done_after_last", 32'(last_prev), 32'd1);
                check_eq("busy_low_at_done", 32'(bus.busy), 32'd0);
            end
            xfer = bus.m_valid && bus.m_ready;
            if (xfer) begin
                accepted++;
                if (beats_run == 0) first_cyc = cyc;
                last_cyc = cyc;
                beats_run++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", 32'(bus.m_index), 32'hFFFF_FFFF);
                end else begin
                    b = exp_q.pop_front();
                    check_eq("beat_data", 32'(bus.m_data), 32'(b.data));
                    check_eq("beat_index", 32'(bus.m_index), 32'(b.idx));
                    check_eq("beat_last", 32'(bus.m_last), 32'(b.last));
                end
            end
            last_prev = xfer && bus.m_last;
            if (issued - accepted > max_out) max_out = issued - accepted;
            prev_stall = bus.m_valid && !bus.m_ready;
            held_data  = bus.m_data;
            held_idx   = bus.m_index;
            held_last  = bus.m_last;
        end
    end

    task automatic sb_load(input logic [7:0] base);
        beat_t      b;
        logic [7:0] a;
        for (int i = 0; i < 25; i++) begin
            a      = base + 8'(i);
            b.data = mem[a];
            b.idx  = 5'(i);
            b.last = (i == 24);
            exp_q.push_back(b);
            addr_q.push_back(a);
        end
    endtask

    task automatic run_map(input logic [7:0] base, input int span);
        int lat;
        int t;
        int d0;
        sb_load(base);
        beats_run = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.start = 1'b1;
        bus.base_position = base;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_eq("busy_after_start", 32'(bus.busy), 32'd1);
        lat = 0;
        while (!bus.m_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("first_valid_latency", 32'(lat), 32'd3);
        d0 = done_cnt;
        t  = 0;
        while (done_cnt == d0 && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("done_pulses", 32'(done_cnt - d0), 32'd1);
        check_eq("beat_count", 32'(beats_run), 32'd25);
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        check_eq("reads_all_issued", 32'(addr_q.size()), 32'd0);
        if (span >= 0) check_eq("beat_span", 32'(last_cyc - first_cyc), 32'(span));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.base_position = 8'd0;
        bus.m_ready = 1'b1;
        for (int a = 0; a < 256; a++) mem[a] = 12'(a * 3);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(bus.m_valid), 32'd0);
        check_eq("rst_last", 32'(bus.m_last), 32'd0);
        check_eq("rst_index", 32'(bus.m_index), 32'd0);
        check_eq("rst_data", 32'(bus.m_data), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.read_done), 32'd0);
        check_eq("rst_rd_en", 32'(bus.L4_output_rd_en), 32'd0);
        check_eq("rst_addr", 32'(bus.L4_output_read_addr), 32'd0);

        // Base 0, ready held high: 25 back-to-back beats (start right after reset release)
        ready_mode = 0;
        run_map(8'd0, 24);

        // Base 50, ready toggling
        ready_mode = 1;
        run_map(8'd50, -1);

        // Ten-cycle stall at index 7
        ready_mode = 2;
        stall_left = 10;
        run_map(8'd0, 34);
        check_eq("stall_consumed", 32'(stall_left), 32'd0);

        // Second start mid-stream is ignored, then a fresh map at base 100
        ready_mode = 0;
        fork
            run_map(8'd20, 24);
            begin
                k = 0;
                while (!(bus.m_valid && bus.m_index == 5'd4) && k < 100) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                bus.start = 1'b1;
                bus.base_position = 8'd77;
                @(posedge clk);
                #1;
                bus.start = 1'b0;
            end
        join
        run_map(8'd100, 24);

        // Reset in the middle of a map at index 12
        sb_load(8'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.base_position = 8'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        k = 0;
        while (!(bus.m_valid && bus.m_index == 5'd12) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("reached_index12", 32'(bus.m_index), 32'd12);
        rst = 1'b1;
        exp_q.delete();
        addr_q.delete();
        @(posedge clk);
        #1;
        check_eq("midrst_valid", 32'(bus.m_valid), 32'd0);
        check_eq("midrst_busy", 32'(bus.busy), 32'd0);
        check_eq("midrst_rd_en", 32'(bus.L4_output_rd_en), 32'd0);
        check_eq("midrst_index", 32'(bus.m_index), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check_eq("midrst_valid_stays_low", 32'(bus.m_valid), 32'd0);
        end
        run_map(8'd0, 24);

        // Address wrap from base 240 with a full-scale word at address 0
        mem[0] = 12'hFFF;
        run_map(8'd240, 24);

        check_eq("max_outstanding_le2", 32'(max_out <= 2), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
